// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit and alu_seq.
// start/select/A/B form the request side; busy/done/Z/carry/dbz form the response side.
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic                 start;
  logic [3:0]           select;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   Z;
  logic                 carry;
  logic                 dbz;

  modport master (
    output start, select, A, B,
    input  busy, done, Z, carry, dbz
  );

  modport slave (
    input  start, select, A, B,
    output busy, done, Z, carry, dbz
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops, shift-add MUL and
// restoring DIV iterating one bit per clock behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state_o
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_NEG = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_ROL = 4'b1110;
  localparam logic [3:0] OP_ROR = 4'b1111;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               carry_q, carry_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [SW-1:0]      sh;
  logic [WIDTH:0]     add_r, sub_r;
  logic [WIDTH-1:0]   rol_r, ror_r;
  logic [WIDTH-1:0]   alu_lo;
  logic               alu_c;

  // MUL/DIV run on magnitudes; signs are reapplied when the result is written.
  always_comb begin
    a_neg = SIGNED && bus.A[WIDTH-1];
    b_neg = SIGNED && bus.B[WIDTH-1];
    a_mag = a_neg ? ('0 - bus.A) : bus.A;
    b_mag = b_neg ? ('0 - bus.B) : bus.B;
  end

  always_comb begin
    sh    = bus.B[SW-1:0];
    add_r = {1'b0, bus.A} + {1'b0, bus.B};
    sub_r = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
    for (int i = 0; i < WIDTH; i++) begin
      rol_r[i] = bus.A[SW'(i) - sh];
      ror_r[i] = bus.A[SW'(i) + sh];
    end
    alu_lo = '0;
    alu_c  = 1'b0;
    case (bus.select)
      OP_ADD: begin alu_lo = add_r[WIDTH-1:0]; alu_c = add_r[WIDTH]; end
      OP_SUB: begin alu_lo = sub_r[WIDTH-1:0]; alu_c = sub_r[WIDTH]; end
      OP_AND: alu_lo = bus.A & bus.B;
      OP_OR:  alu_lo = bus.A | bus.B;
      OP_NEG: alu_lo = '0 - bus.A;
      OP_ASR: begin
        if (SIGNED) alu_lo = $unsigned($signed(bus.A) >>> sh);
        else        alu_lo = bus.A >> sh;
      end
      OP_NOT: alu_lo = ~bus.A;
      OP_SHL: alu_lo = bus.A << sh;
      OP_SHR: alu_lo = bus.A >> sh;
      OP_ROL: alu_lo = rol_r;
      OP_ROR: alu_lo = ror_r;
      default: ;
    endcase
  end

  // acc holds {HI, LO}: MUL keeps multiplier in LO, DIV keeps remainder in HI, quotient in LO.
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_step, div_step, mul_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               last_iter;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};
    if (!div_trial[WIDTH]) div_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else                   div_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    mul_fix   = neg_res_q ? ('0 - mul_step) : mul_step;
    quo_fix   = neg_res_q ? ('0 - div_step[WIDTH-1:0]) : div_step[WIDTH-1:0];
    rem_fix   = neg_rem_q ? ('0 - div_step[2*WIDTH-1:WIDTH]) : div_step[2*WIDTH-1:WIDTH];
    last_iter = (cnt_q == SW'(WIDTH - 1));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    z_d       = z_q;
    carry_d   = carry_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          done_d = 1'b1;
          case (bus.select)
            OP_MUL: begin
              state_d   = S_MUL;
              done_d    = 1'b0;
              cnt_d     = '0;
              acc_d     = {{WIDTH{1'b0}}, b_mag};
              opb_d     = a_mag;
              neg_res_d = a_neg ^ b_neg;
            end
            OP_DIV: begin
              if (bus.B == '0) begin
                z_d     = {bus.A, {WIDTH{1'b1}}};
                carry_d = 1'b0;
                dbz_d   = 1'b1;
              end else begin
                state_d   = S_DIV;
                done_d    = 1'b0;
                cnt_d     = '0;
                acc_d     = {{WIDTH{1'b0}}, a_mag};
                opb_d     = b_mag;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
              end
            end
            4'b0000, 4'b0100, 4'b1011: ;
            default: begin
              z_d     = {{WIDTH{1'b0}}, alu_lo};
              carry_d = alu_c;
              dbz_d   = 1'b0;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + SW'(1);
        if (last_iter) begin
          state_d = S_IDLE;
          z_d     = mul_fix;
          carry_d = 1'b0;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DIV: begin
        acc_d = div_step;
        cnt_d = cnt_q + SW'(1);
        if (last_iter) begin
          state_d = S_IDLE;
          z_d     = {rem_fix, quo_fix};
          carry_d = 1'b0;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      z_q       <= '0;
      carry_q   <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      z_q       <= z_d;
      carry_q   <= carry_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.Z       = z_q;
  assign bus.carry   = carry_q;
  assign bus.dbz     = dbz_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: the driver pushes hand-computed {dbz, carry, Z} per request,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_seq;
  localparam int W = 32;

  localparam logic [3:0] ADD = 4'b0001, SUB = 4'b0010, MUL = 4'b0011, DIV = 4'b0101;
  localparam logic [3:0] AND_ = 4'b0110, OR_ = 4'b0111, NEG = 4'b1000, ASR = 4'b1001;
  localparam logic [3:0] NOT_ = 4'b1010, SHL = 4'b1100, SHR = 4'b1101, ROL = 4'b1110;
  localparam logic [3:0] ROR = 4'b1111;

  // clock / reset
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq_if #(.WIDTH(W)) ubus ();
  logic [1:0] dbg_s, dbg_u;

  alu_seq #(.WIDTH(W), .SIGNED(1'b1)) dut (
    .clk(clk), .clr(clr), .bus(bus), .dbg_state_o(dbg_s)
  );
  alu_seq #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .clr(clr), .bus(ubus), .dbg_state_o(dbg_u)
  );

  int checks = 0;
  int errors = 0;
  logic [2*W+1:0] exp_q[$];
  logic [2*W+1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!clr && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        check("result_z", bus.Z, mon_e[63:0]);
        check("result_carry", {63'b0, bus.carry}, {63'b0, mon_e[64]});
        check("result_dbz", {63'b0, bus.dbz}, {63'b0, mon_e[65]});
      end
    end
  end

  // driver tasks
  task automatic push(input logic [63:0] z, input logic c, input logic d);
    exp_q.push_back({d, c, z});
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.select = op;
    bus.A      = a;
    bus.B      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int busy_cycles, output bit seen, output bit z_moved);
    logic [63:0] z0;
    z0 = bus.Z;
    busy_cycles = 0;
    seen = 1'b0;
    z_moved = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) begin
        busy_cycles++;
        if (bus.Z !== z0) z_moved = 1'b1;
      end
    end
  endtask

  int  nb;
  bit  seen, moved;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.select = '0; bus.A = '0; bus.B = '0;
    ubus.start = 1'b0; ubus.select = '0; ubus.A = '0; ubus.B = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("reset_z", bus.Z, 64'h0);
    check("reset_busy", {63'b0, bus.busy}, 64'h0);
    check("reset_done", {63'b0, bus.done}, 64'h0);
    check("reset_carry_dbz", {62'b0, bus.carry, bus.dbz}, 64'h0);
    check("reset_state", {62'b0, dbg_s}, 64'h0);

    // add / sub / opcode holes, back to back
    push(64'h0, 1'b1, 1'b0);                    send(ADD, 32'hFFFFFFFF, 32'h1);
    push(64'h00000000_FFFFFFFE, 1'b0, 1'b0);    send(SUB, 32'd5, 32'd7);
    push(64'h00000000_00000002, 1'b1, 1'b0);    send(SUB, 32'd7, 32'd5);
    push(64'h00000000_00000001, 1'b1, 1'b0);    send(ADD, 32'hFFFFFFFF, 32'h2);
    push(64'h00000000_00000001, 1'b1, 1'b0);    send(4'b0100, 32'd123, 32'd456);
    push(64'h00000000_00000001, 1'b1, 1'b0);    send(4'b0000, 32'd9, 32'd9);
    bus.start = 1'b0;

    // clr on the 10th MUL iteration aborts it without a done pulse
    send(MUL, 32'd5, 32'd6);
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("clr_busy", {63'b0, bus.busy}, 64'h0);
    check("clr_z", bus.Z, 64'h0);
    check("clr_done", {63'b0, bus.done}, 64'h0);
    check("clr_state", {62'b0, dbg_s}, 64'h0);
    push(64'h00000000_00000007, 1'b0, 1'b0);    send(ADD, 32'd3, 32'd4);
    bus.start = 1'b0;

    // MUL
    push(64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b0);    send(MUL, 32'hFFFFFFFD, 32'd7);
    bus.start = 1'b0;
    wait_done(nb, seen, moved);
    check("mul_done_seen", {63'b0, seen}, 64'h1);
    check("mul_busy_cycles", 64'(nb), 64'd32);
    check("mul_z_held", {63'b0, moved}, 64'h0);
    push(64'h40000000_00000000, 1'b0, 1'b0);    send(MUL, 32'h80000000, 32'h80000000);
    bus.start = 1'b0;
    wait_done(nb, seen, moved);
    check("mulmin_done_seen", {63'b0, seen}, 64'h1);

    ubus.start = 1'b1; ubus.select = MUL; ubus.A = 32'hFFFFFFFF; ubus.B = 32'd2;
    @(posedge clk);
    #1 ubus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ubus.done) seen = 1'b1;
    end
    check("umul_done_seen", {63'b0, seen}, 64'h1);
    check("umul_z", ubus.Z, 64'h00000001_FFFFFFFE);

    // DIV
    push(64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0);    send(DIV, 32'hFFFFFFF9, 32'd2);
    bus.start = 1'b0;
    wait_done(nb, seen, moved);
    check("div_busy_cycles", 64'(nb), 64'd32);
    check("div_z_held", {63'b0, moved}, 64'h0);
    push(64'h00000000_80000000, 1'b0, 1'b0);    send(DIV, 32'h80000000, 32'hFFFFFFFF);
    bus.start = 1'b0;
    wait_done(nb, seen, moved);
    check("divmin_done_seen", {63'b0, seen}, 64'h1);
    push(64'h00000001_FFFFFFFD, 1'b0, 1'b0);    send(DIV, 32'd7, 32'hFFFFFFFE);
    bus.start = 1'b0;
    wait_done(nb, seen, moved);
    check("divneg_done_seen", {63'b0, seen}, 64'h1);
    push(64'h00000009_FFFFFFFF, 1'b0, 1'b1);    send(DIV, 32'd9, 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    check("div0_busy", {63'b0, bus.busy}, 64'h0);
    check("div0_done", {63'b0, bus.done}, 64'h1);

    // shifts, rotates, logic back to back
    push(64'h00000000_00000003, 1'b0, 1'b0);    send(ROL, 32'h80000001, 32'd33);
    push(64'h00000000_F8000000, 1'b0, 1'b0);    send(ASR, 32'h80000000, 32'd4);
    push(64'h00000000_08000000, 1'b0, 1'b0);    send(SHR, 32'h80000000, 32'd4);
    push(64'h00000000_80000000, 1'b0, 1'b0);    send(SHL, 32'h00000001, 32'd31);
    push(64'h00000000_80000000, 1'b0, 1'b0);    send(ROR, 32'h00000001, 32'd1);
    push(64'h00000000_12345678, 1'b0, 1'b0);    send(ROL, 32'h12345678, 32'd32);
    push(64'h00000000_0000F000, 1'b0, 1'b0);    send(AND_, 32'h0000F0F0, 32'h0000FF00);
    push(64'h00000000_0000FFF0, 1'b0, 1'b0);    send(OR_, 32'h0000F0F0, 32'h0000FF00);
    push(64'h00000000_FFFFFFFF, 1'b0, 1'b0);    send(NOT_, 32'h0, 32'h0);
    push(64'h00000000_FFFFFFFF, 1'b0, 1'b0);    send(NEG, 32'h1, 32'h0);
    bus.start = 1'b0;

    // start while busy is dropped; start on the done cycle is taken
    push(64'h00000002_0000000E, 1'b0, 1'b0);    send(DIV, 32'd100, 32'd7);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(ADD, 32'd1, 32'd1);
    bus.start = 1'b0;
    wait_done(nb, seen, moved);
    check("busy_div_done_seen", {63'b0, seen}, 64'h1);
    push(64'h00000000_0000001E, 1'b0, 1'b0);    send(ADD, 32'd10, 32'd20);
    bus.start = 1'b0;
    @(negedge clk);
    check("done_second_cycle", {63'b0, bus.done}, 64'h1);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
